div4_seq: RTL

Sequential 4-bit restoring divider for the lab ALU datapath. It sits alongside the `Resta4bits` subtractor and reuses its trial-subtraction arithmetic one bit per clock, producing a quotient and remainder for the downstream display/flag stage. Operands are captured on a start handshake. Results hold stable until the next accepted start.

---
 rtl/div4_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/div4_seq.sv
// Sequential 4-bit restoring divider: one trial subtraction per clock, 6-cycle latency.
// Optional build macro DIV4_SIGNED_EN selects two's-complement operands with sign fix-up.

// 4-bit ripple-borrow subtractor; negative reports the borrow out of the MSB.
module resta4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] diff,
    output logic       negative
);
    logic [4:0] borrow;

    assign borrow[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign diff[gi]       = a[gi] ^ b[gi] ^ borrow[gi];
            assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
        end
    endgenerate

    assign negative = borrow[4];
endmodule

module div4_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ovf
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] p_q, p_d;
    logic [3:0] dvd_q, dvd_d;
    logic [3:0] dvs_q, dvs_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       ovf_q, ovf_d;

    logic [4:0] p_shift;
    logic [3:0] sub_lo;
    logic       sub_borrow;
    logic       trial_neg;
    logic [4:0] trial_val;
    logic [3:0] fix_q;
    logic [3:0] fix_r;
    logic       fix_ovf;

    function automatic logic [3:0] mag4(input logic [3:0] v);
`ifdef DIV4_SIGNED_EN
        // -8 maps onto 4'b1000, which the unsigned core handles directly.
        return v[3] ? (~v + 4'd1) : v;
`else
        return v;
`endif
    endfunction

    // The 5-bit trial is split: Resta4bits covers the low nibble, P[4] absorbs its borrow.
    assign p_shift   = {p_q[3:0], dvd_q[3]};
    resta4bits u_sub (
        .a        (p_shift[3:0]),
        .b        (dvs_q),
        .diff     (sub_lo),
        .negative (sub_borrow)
    );
    assign trial_neg = ~p_shift[4] & sub_borrow;
    assign trial_val = {p_shift[4] ^ sub_borrow, sub_lo};

    always_comb begin
        fix_q   = dvd_q;
        fix_r   = p_q[3:0];
        fix_ovf = 1'b0;
`ifdef DIV4_SIGNED_EN
        if (a_q[3] ^ b_q[3]) begin
            fix_q = ~dvd_q + 4'd1;
        end
        if (a_q[3]) begin
            fix_r = ~p_q[3:0] + 4'd1;
        end
        if ((a_q == 4'h8) && (b_q == 4'hF)) begin
            fix_q   = 4'h8;
            fix_r   = 4'h0;
            fix_ovf = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d    = A;
                    b_d    = B;
                    p_d    = 5'd0;
                    dvd_d  = mag4(A);
                    dvs_d  = mag4(B);
                    cnt_d  = 2'd0;
                    busy_d = 1'b1;
                    state_d = (B == 4'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                // Quotient bits shift in behind the consumed dividend bits.
                p_d   = trial_neg ? p_shift : trial_val;
                dvd_d = {dvd_q[2:0], ~trial_neg};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (b_q == 4'd0) begin
                    q_d   = 4'hF;
                    r_d   = a_q;
                    err_d = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    q_d   = fix_q;
                    r_d   = fix_r;
                    err_d = 1'b0;
                    ovf_d = fix_ovf;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_q     <= 5'd0;
            dvd_q   <= 4'd0;
            dvs_q   <= 4'd0;
            cnt_q   <= 2'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            q_q     <= 4'd0;
            r_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign ovf  = ovf_q;
endmodule
